// File: rtl/usbf_ep_rf_param_if.sv
// Register-file bus shared by the endpoint register files: select, strobes and data.
interface usbf_ep_rf_param_if;
    logic [1:0]  adr;
    logic        re;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output adr, re, we, din, input dout);
    modport slave  (input adr, re, we, din, output dout);
endinterface

// File: rtl/usbf_ep_rf_param.sv
// Single USB endpoint register file: CSR, interrupt, buffer 0/1 and the DMA byte counter.
// EP_EXISTS=0 drops all storage and ties outputs to the unpopulated-endpoint values.
module usbf_ep_rf_param #(
    parameter int          EP_EXISTS = 1,
    parameter int          DMA_CNT_W = 14,
    parameter logic [31:0] CSR_RST   = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    usbf_ep_rf_param_if.slave bus,
    output logic              inta,
    output logic              intb,
    output logic              dma_req,
    input  logic              dma_ack,
    input  logic [31:0]       idin,
    input  logic [3:0]        ep_sel,
    output logic              ep_match,
    input  logic              buf0_rl,
    input  logic              buf0_set,
    input  logic              buf1_set,
    input  logic              uc_bsel_set,
    input  logic              uc_dpd_set,
    input  logic              int_to_set,
    input  logic              int_crc16_set,
    input  logic              int_upid_set,
    input  logic              int_buf0_set,
    input  logic              int_buf1_set,
    input  logic              int_seqerr_set,
    input  logic              out_to_small,
    output logic [31:0]       csr,
    output logic [31:0]       buf0,
    output logic [31:0]       buf1,
    output logic              dma_in_buf_sz1,
    output logic              dma_out_buf_avail
);
    generate
        if (EP_EXISTS != 0) begin : g_ep
            // Two spare bits so the counter arithmetic can go negative or overflow before clamping.
            localparam int SW = ((DMA_CNT_W > 14) ? DMA_CNT_W : 14) + 2;
            localparam logic [SW-1:0] CNT_MAX = {{(SW-DMA_CNT_W){1'b0}}, {DMA_CNT_W{1'b1}}};
            localparam logic [SW-1:0] WORD    = SW'(4);

            logic [31:0]          csr_q, buf0_q, buf1_q, buf0_sh, dout_mux;
            logic [6:0]           stat, iena, ienb, ev;
            logic [DMA_CNT_W-1:0] cnt, cnt_nxt;
            logic [SW-1:0]        cnt_x, mps_x, bsz_x, add_x, sub_x, sum_x, room_x;
            logic                 dir_in, dir_out, dma_act, req_cond;
            logic                 inta_q, intb_q, req_q;
            logic                 csr_we, int_we, buf0_we, buf1_we, int_rd;

            assign csr_we  = bus.we && (bus.adr == 2'd0);
            assign int_we  = bus.we && (bus.adr == 2'd1);
            assign buf0_we = bus.we && (bus.adr == 2'd2);
            assign buf1_we = bus.we && (bus.adr == 2'd3);
            assign int_rd  = bus.re && (bus.adr == 2'd1);
            assign ev = {out_to_small, int_seqerr_set, int_buf1_set, int_buf0_set,
                         int_upid_set, int_crc16_set, int_to_set};

            assign dir_in  = (csr_q[27:26] == 2'b01);
            assign dir_out = (csr_q[27:26] == 2'b10);
            assign dma_act = csr_q[15] && (dir_in || dir_out);
            assign cnt_x   = SW'(cnt);
            assign mps_x   = SW'(csr_q[10:0]);
            assign bsz_x   = SW'(buf0_q[30:17]);
            assign room_x  = bsz_x - cnt_x;

            always_comb begin
                add_x = '0;
                sub_x = '0;
                if (dir_in) begin
                    if (dma_ack)  add_x = WORD;
                    if (buf0_set) sub_x = mps_x;
                end else if (dir_out) begin
                    if (buf0_set) add_x = mps_x;
                    if (dma_ack)  sub_x = WORD;
                end
                sum_x = cnt_x + add_x - sub_x;
                if (sum_x[SW-1])          cnt_nxt = '0;
                else if (sum_x > CNT_MAX) cnt_nxt = '1;
                else                      cnt_nxt = sum_x[DMA_CNT_W-1:0];
            end

            assign req_cond = dir_in ? ((cnt_x + WORD) <= bsz_x) : (dir_out && (cnt_x >= WORD));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    csr_q <= {4'b0, CSR_RST[27:0]};
                end else begin
                    if (csr_we)      csr_q[27:0]  <= bus.din[27:0];
                    if (uc_bsel_set) csr_q[31:30] <= idin[31:30];
                    if (uc_dpd_set)  csr_q[29:28] <= idin[29:28];
                end
            end

            // A status event landing on the clearing read survives it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stat   <= '0;
                    iena   <= '0;
                    ienb   <= '0;
                    inta_q <= 1'b0;
                    intb_q <= 1'b0;
                end else begin
                    stat   <= (int_rd ? 7'd0 : stat) | ev;
                    inta_q <= |(stat & iena);
                    intb_q <= |(stat & ienb);
                    if (int_we) begin
                        iena <= bus.din[30:24];
                        ienb <= bus.din[22:16];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    buf0_q  <= '1;
                    buf1_q  <= '1;
                    buf0_sh <= '1;
                end else begin
                    if (buf0_we)      buf0_sh <= bus.din;
                    if (buf0_set)     buf0_q  <= idin;
                    else if (buf0_we) buf0_q  <= bus.din;
                    else if (buf0_rl) buf0_q  <= buf0_sh;
                    if (buf1_set)     buf1_q  <= idin;
                    else if (buf1_we) buf1_q  <= bus.din;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt   <= '0;
                    req_q <= 1'b0;
                end else begin
                    if (csr_we && !bus.din[15]) cnt <= '0;
                    else if (dma_act)           cnt <= cnt_nxt;
                    // Request is held until acknowledged, then re-evaluated a cycle later.
                    if (!dma_act)   req_q <= 1'b0;
                    else if (req_q) req_q <= !dma_ack;
                    else            req_q <= req_cond;
                end
            end

            always_comb begin
                dout_mux = csr_q;
                case (bus.adr)
                    2'd0: dout_mux = csr_q;
                    2'd1: dout_mux = {1'b0, iena, 1'b0, ienb, 9'b0, stat};
                    2'd2: dout_mux = buf0_q;
                    2'd3: dout_mux = buf1_q;
                    default: dout_mux = csr_q;
                endcase
            end

            assign bus.dout          = dout_mux;
            assign inta              = inta_q;
            assign intb              = intb_q;
            assign dma_req           = req_q;
            assign ep_match          = (csr_q[21:18] == ep_sel);
            assign csr               = csr_q;
            assign buf0              = buf0_q;
            assign buf1              = buf1_q;
            assign dma_in_buf_sz1    = dir_in && (cnt_x >= mps_x);
            assign dma_out_buf_avail = dir_out && !room_x[SW-1] && (room_x >= mps_x);
        end else begin : g_stub
            assign bus.dout          = '0;
            assign inta              = 1'b0;
            assign intb              = 1'b0;
            assign dma_req           = 1'b0;
            assign ep_match          = 1'b0;
            assign csr               = '0;
            assign buf0              = '1;
            assign buf1              = '1;
            assign dma_in_buf_sz1    = 1'b0;
            assign dma_out_buf_avail = 1'b0;
        end
    endgenerate
endmodule

// File: doc/usbf_ep_rf_param.md
# usbf_ep_rf_param

Parametrised single-endpoint register file for the USB function core, replacing both the full and the dummy endpoint register files with one block. It holds CSR, interrupt, and buffer 0/1 registers. It maintains a DMA byte counter that drives the DMA request handshake and the IN/OUT buffer-availability flags. With `EP_EXISTS=0` it collapses to constant termination values for unpopulated endpoints.

## Interface
- `EP_EXISTS`, 1: 1 instantiates the full endpoint; 0 forces every output to its termination constant and removes all storage.
- `DMA_CNT_W`, 14: byte-counter width, matching the 14-bit buffer-size field `buf0[30:17]`.
- `CSR_RST`, 32'h0: reset value of the writable CSR bits.
- `clk` in 1: single clock (already decided).
- `rst` in 1: asynchronous, active-low reset (already decided).
- `adr` in 2: register select, with 0=CSR, 1=INT, 2=BUF0, 3=BUF1.
- `re` / `we` in 1: bus read / write strobes (single-cycle).
- `din` in 32: bus write data.
- `dout` out 32: bus read data, a combinational mux on `adr`.
- `inta` / `intb` out 1: interrupt lines.
- `dma_req` out 1: DMA word-transfer request.
- `dma_ack` in 1: one-cycle acknowledge, one 4-byte word per ack.
- `idin` in 32: internal update data from the protocol engine.
- `ep_sel` in 4: endpoint number under access.
- `ep_match` out 1: `EP_EXISTS && csr[21:18]==ep_sel` (combinational).
- `buf0_rl` in 1: reload BUF0 from its shadow.
- `buf0_set` / `buf1_set` in 1: load BUF0 / BUF1 from `idin`.
- `uc_bsel_set` / `uc_dpd_set` in 1: load `csr[31:30]` / `csr[29:28]` from `idin` bits of the same positions.
- `int_to_set`, `int_crc16_set`, `int_upid_set`, `int_buf0_set`, `int_buf1_set`, `int_seqerr_set`, `out_to_small` in 1 each: interrupt event strobes (status bits 0..6, in this order).
- `csr`, `buf0`, `buf1` out 32: internal register views.
- `dma_in_buf_sz1` / `dma_out_buf_avail` out 1: DMA buffer flags.

## Operation
- CSR fields:
  - [31:30] `uc_bsel`, [29:28] `uc_dpd`: internal only; bus writes ignore them.
  - [27:26] direction: 01 = IN, 10 = OUT, 00/11 = no DMA.
  - [21:18] `ep_no`.
  - [15] `dma_en`.
  - [10:0] `max_pl_sz` in bytes.
  - Bus write updates [27:0].
- INT register:
  - [30:24] `iena`, [22:16] `ienb`, both bus-writable.
  - [6:0] status, read-only.
  - Each event strobe sets its status bit.
  - A bus read of INT (`re && adr==1`) clears all status bits on the next edge. An event coincident with the clearing read is retained (set wins).
  - `inta = |(stat & iena)`, `intb = |(stat & ienb)`, both registered.
- BUF0 / BUF1:
  - A bus write loads both the live register and, for BUF0, the shadow.
  - `buf0_set` / `buf1_set` load the live register only, and win over a same-cycle bus write to the live register. The shadow still takes the bus data.
  - `buf0_rl` copies shadow to live, and has priority below `buf0_set`.
- DMA counter `cnt` (bytes), active only when `dma_en=1` and direction is IN or OUT:
  - IN: `dma_ack` adds 4, `buf0_set` subtracts `max_pl_sz`.
  - OUT: `buf0_set` adds `max_pl_sz`, `dma_ack` subtracts 4.
  - Coincident events apply their net effect in one cycle. Results saturate at 0 and at `2^DMA_CNT_W-1`.
  - A CSR write clearing `dma_en` resets `cnt` to 0.
- `dma_in_buf_sz1 = IN && cnt >= max_pl_sz`.
- `dma_out_buf_avail = OUT && (buf0[30:17] - cnt) >= max_pl_sz`, with the subtraction evaluated signed so a negative result gives 0.
- `dma_req` handshake:
  - Rises when IN and `cnt+4 <= buf0[30:17]`, or when OUT and `cnt >= 4`.
  - Held until `dma_ack`, drops the cycle after ack, then is re-evaluated.
  - Never deasserts without an ack unless `dma_en` is cleared.
- `EP_EXISTS=0`: `dout`=0, `inta`/`intb`/`dma_req`/`ep_match`=0, `csr`=0, `buf0`/`buf1`=32'hffff_ffff, both DMA flags 0.

## Timing
- Reset values:
  - `csr` = {4'b0, `CSR_RST[27:0]`}.
  - INT = 0.
  - BUF0 / BUF1 / shadow = 32'hffff_ffff.
  - `cnt` = 0; `dma_req`, `inta`, `intb` = 0.
- A reset assertion mid-handshake drops `dma_req` immediately (asynchronously).
- Register writes are visible on `dout` / `csr` / `buf*` one cycle after `we`.
- Interrupts: status is set at edge N, and `inta` / `intb` assert at edge N+1.
- DMA: ack at edge N updates `cnt` at N. `dma_req` is low after N and may re-assert at N+1 from the updated `cnt`.
- Flags are combinational from registered state (zero extra latency).

## Test plan
- Reset, then read all 4 addresses: CSR = `CSR_RST` & 32'h0fff_ffff, INT = 0, BUF0 = BUF1 = 32'hffff_ffff, `dma_req` = 0.
- Set `iena`=7'h08, pulse `int_buf0_set` → `inta`=1 two edges later and `intb`=0. Read INT while `int_to_set` pulses in the same cycle → afterwards status=7'h01.
- IN, `max_pl_sz`=64, buf size 256, `dma_en`=1: ack 16 times → `cnt`=64 and `dma_in_buf_sz1`=1. Pulse `buf0_set` in the same cycle as an ack → `cnt`=4.
- OUT, `max_pl_sz`=64, size 128: two `buf0_set` → `cnt`=128 and `dma_out_buf_avail`=0. One ack → `cnt`=124 and `dma_out_buf_avail`=0.
- Bus write BUF0=32'h0010_0000 together with `buf0_set` (`idin`=32'h1) → BUF0=1. Then `buf0_rl` → BUF0=32'h0010_0000.
- `EP_EXISTS=0`: random bus and strobe traffic → all outputs stay at the termination constants every cycle.
